shift_sequencer: RTL and testbench

Multi-cycle controller for the shift datapath: shift-amount source mux plus shift register. On a `start` from the main control unit it:
- drives the amount mux select;
- captures the selected amount;
- loads the shift register;
- issues one single-position shift command per cycle until the amount is exhausted, then pulses `done`.

This lets the main FSM issue SLL/SRL/SRA (immediate or variable) as a single request and wait on `done`.

---
 rtl/shift_ctrl_pkg.sv | 46 ++++
 rtl/shift_counter.sv | 37 +++
 rtl/shift_sequencer.sv | 118 +++++++++++
 tb/tb_shift_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift datapath controller and the main control unit.
package shift_ctrl_pkg;

    localparam int MAX_SHIFT = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SRC_SHAMT = 2'b00,
        SRC_C16   = 2'b01,
        SRC_RS    = 2'b10,
        SRC_MEM   = 2'b11
    } src_e;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_LOAD    = 3'b001,
        CMD_LEFT    = 3'b010,
        CMD_RIGHT_L = 3'b011,
        CMD_RIGHT_A = 3'b100
    } sh_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic sh_cmd_e op_to_cmd(op_e op);
        case (op)
            OP_SLL:  return CMD_LEFT;
            OP_SRL:  return CMD_RIGHT_L;
            OP_SRA:  return CMD_RIGHT_A;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/shift_counter.sv
// Loadable down-counter for the remaining shift distance; clamps the loaded amount.
module shift_counter #(
    parameter int IN_W = 6,
    parameter int MAX  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            dec,
    input  logic [IN_W-1:0] load_val,
    output logic            last,
    output logic            zero
);
    import shift_ctrl_pkg::*;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] clamped;

    always_comb begin
        clamped = CNT_W'(load_val);
        if (int'(load_val) > MAX)
            clamped = CNT_W'(MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= clamped;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign last = (cnt == CNT_W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Sequences amount select, shifter load and one single-bit shift per cycle, then pulses done.
module shift_sequencer #(
    parameter int AMT_W     = 6,
    parameter int MAX_SHIFT = shift_ctrl_pkg::MAX_SHIFT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [1:0]       src,
    input  logic [AMT_W-1:0] amt_in,
    output logic [2:0]       amt_sel,
    output logic [2:0]       sh_cmd,
    output logic [4:0]       sh_n,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import shift_ctrl_pkg::*;

    state_e  state;
    op_e     op_q;
    sh_cmd_e cmd_q;
    logic    cnt_last;
    logic    cnt_zero;

    // Counter captures the settled mux output at the end of SELECT.
    shift_counter #(
        .IN_W (AMT_W),
        .MAX  (MAX_SHIFT)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_SELECT),
        .dec      (state == ST_SHIFT),
        .load_val (amt_in),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_SLL;
            cmd_q   <= CMD_NOP;
            amt_sel <= 3'b000;
            sh_n    <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_q <= CMD_NOP;
                    sh_n  <= 5'd0;
                    busy  <= 1'b0;
                    if (start && !abort) begin
                        if (op_e'(op) == OP_ILL) begin
                            err <= 1'b1;
                        end else begin
                            state   <= ST_SELECT;
                            op_q    <= op_e'(op);
                            amt_sel <= {1'b0, src};
                            busy    <= 1'b1;
                        end
                    end
                end
                ST_SELECT: begin
                    state <= ST_LOAD;
                    cmd_q <= CMD_LOAD;
                end
                ST_LOAD: begin
                    if (!cnt_zero) begin
                        state <= ST_SHIFT;
                        cmd_q <= op_to_cmd(op_q);
                        sh_n  <= 5'd1;
                    end else begin
                        state <= ST_DONE;
                        cmd_q <= CMD_NOP;
                        done  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_last) begin
                        state <= ST_DONE;
                        cmd_q <= CMD_NOP;
                        sh_n  <= 5'd0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    amt_sel <= 3'b000;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Abort drops everything without a completion pulse.
            if (state != ST_IDLE && abort) begin
                state   <= ST_IDLE;
                cmd_q   <= CMD_NOP;
                sh_n    <= 5'd0;
                busy    <= 1'b0;
                done    <= 1'b0;
                amt_sel <= 3'b000;
            end
        end
    end

    assign sh_cmd = cmd_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: per-cycle expected output words, checked at negedge.
module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] op = 2'b00;
    logic [1:0] src = 2'b00;
    logic [5:0] amt_in = 6'd0;
    logic [2:0] amt_sel;
    logic [2:0] sh_cmd;
    logic [4:0] sh_n;
    logic       busy;
    logic       done;
    logic       err;

    shift_sequencer #(
        .AMT_W     (6),
        .MAX_SHIFT (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .op      (op),
        .src     (src),
        .amt_in  (amt_in),
        .amt_sel (amt_sel),
        .sh_cmd  (sh_cmd),
        .sh_n    (sh_n),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tcyc;
        logic [13:0] word;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [13:0] act_word;
    assign act_word = {amt_sel, sh_cmd, sh_n, busy, done, err};

    function automatic logic [13:0] pack(logic [2:0] a, logic [2:0] c, logic [4:0] n,
                                         logic b, logic d, logic e);
        return {a, c, n, b, d, e};
    endfunction

    task automatic check(string name, logic [13:0] act, logic [13:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got amt_sel=%b sh_cmd=%b sh_n=%0d busy=%b done=%b err=%b, expected amt_sel=%b sh_cmd=%b sh_n=%0d busy=%b done=%b err=%b",
                     name, act[13:11], act[10:8], act[7:3], act[2], act[1], act[0],
                     exp[13:11], exp[10:8], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: compare every scheduled slot in the cycle it belongs to.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tcyc <= cyc) begin
            e = sb.pop_front();
            if (e.tcyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: slot for cycle %0d missed at cycle %0d", e.name, e.tcyc, cyc);
            end else begin
                check(e.name, act_word, e.word);
            end
        end
    end

    function automatic logic [2:0] cmd_for(logic [1:0] o);
        case (o)
            2'b00:   return 3'b010;
            2'b01:   return 3'b011;
            2'b10:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // done_k: hand-computed cycle of the done pulse (3 + clamped amount).
    // abort_k/start_k: cycle in which abort/start is held high (0 = never).
    // stop_k: cut the run short after this many cycles (0 = full run).
    task automatic run_op(string name, logic [1:0] o, logic [1:0] s, logic [5:0] a,
                          int done_k, int abort_k, int start_k, int stop_k);
        int c;
        int last_k;
        logic [13:0] w;
        logic [2:0] asel;
        @(negedge clk);
        op = o;
        src = s;
        amt_in = a;
        start = 1'b1;
        abort = 1'b0;
        c = cyc;
        asel = {1'b0, s};
        last_k = (abort_k > 0) ? abort_k + 2 : done_k + 1;
        if (stop_k > 0) last_k = stop_k;
        for (int k = 1; k <= last_k; k++) begin
            if (abort_k > 0 && k > abort_k)  w = '0;
            else if (o == 2'b11)             w = (k == 1) ? pack(3'b000, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1) : '0;
            else if (k == 1)                 w = pack(asel, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0);
            else if (k == 2)                 w = pack(asel, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
            else if (k < done_k)             w = pack(asel, cmd_for(o), 5'd1, 1'b1, 1'b0, 1'b0);
            else if (k == done_k)            w = pack(asel, 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);
            else                             w = '0;
            sb.push_back('{c + k, w, $sformatf("%s c%0d", name, k)});
        end
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            start = (k == start_k);
            abort = (k == abort_k);
            if (k == 1) begin
                op = ~o;
                src = ~s;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        check("reset_state", act_word, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op("sll_amt5",    2'b00, 2'b00, 6'd5,  8,  0, 0, 0);
        run_op("sra_c16",     2'b10, 2'b01, 6'd16, 19, 0, 0, 0);
        run_op("srl_amt0",    2'b01, 2'b10, 6'd0,  3,  0, 0, 0);
        run_op("srl_amt1",    2'b01, 2'b11, 6'd1,  4,  0, 0, 0);
        run_op("sll_amt32",   2'b00, 2'b00, 6'd32, 35, 0, 0, 0);
        run_op("sll_clamp45", 2'b00, 2'b11, 6'd45, 35, 0, 0, 0);
        run_op("sll_abort",   2'b00, 2'b00, 6'd10, 13, 5, 4, 0);
        run_op("illegal_op",  2'b11, 2'b01, 6'd7,  1,  0, 0, 0);

        // start together with abort in IDLE must do nothing
        @(negedge clk);
        op = 2'b00;
        src = 2'b01;
        amt_in = 6'd3;
        start = 1'b1;
        abort = 1'b1;
        c = cyc;
        sb.push_back('{c + 1, 14'd0, "start_abort c1"});
        sb.push_back('{c + 2, 14'd0, "start_abort c2"});
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of SHIFT
        run_op("rst_mid", 2'b00, 2'b00, 6'd5, 8, 0, 0, 3);
        check("rst_pre_shift", act_word, pack(3'b000, 3'b010, 5'd1, 1'b1, 1'b0, 1'b0));
        #2 reset = 1'b1;
        #1 check("rst_async_clear", act_word, '0);
        @(negedge clk);
        reset = 1'b0;
        run_op("sll_after_rst", 2'b00, 2'b00, 6'd5, 8, 0, 0, 0);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected slots left unchecked, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time %0t reached, expected completion earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
